// File: rtl/regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_write_scheduler
//
// Purpose:
//   Owns the five-phase counter (0..4) that sequences the CPU register file and
//   arbitrates the single register-file write slot. The slot occurs in phase 4.
//   Three sources compete for it: CPU writeback, the keypad pending-mask
//   register and the millisecond timer register. Keypad and timer values reach
//   the register file only through scheduled writes on this one port.
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   reset        in   synchronous, active-high
//   stall        in   holds the phase counter (the timer keeps running)
//   counter      out  current phase 0..4
//   cpu_wr_req   in   CPU writeback request, held until cpu_wr_ack
//   cpu_wr_addr  in   CPU destination register
//   cpu_wr_data  in   CPU write data
//   cpu_wr_ack   out  one-cycle pulse when the CPU request is consumed
//   keypad       in   synchronised keypad levels
//   rf_we        out  register file write enable (first cycle of phase 4 only)
//   rf_addr      out  register file write address
//   rf_wdata     out  register file write data
//   milliseconds out  free-running millisecond count
// -----------------------------------------------------------------------------
module regfile_write_scheduler #(
  parameter int WIDTH      = 32,
  parameter int KEY_BITS   = 20,
  parameter int KEY_REG    = 29,
  parameter int TIMER_REG  = 31,
  parameter int CLK_PER_MS = 50000,
  parameter int MAX_DEFER  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  output logic [2:0]          counter,
  input  logic                cpu_wr_req,
  input  logic [4:0]          cpu_wr_addr,
  input  logic [WIDTH-1:0]    cpu_wr_data,
  output logic                cpu_wr_ack,
  input  logic [KEY_BITS-1:0] keypad,
  output logic                rf_we,
  output logic [4:0]          rf_addr,
  output logic [WIDTH-1:0]    rf_wdata,
  output logic [WIDTH-1:0]    milliseconds
);

  localparam int PRE_W = $clog2(CLK_PER_MS);
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_MS - 1);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [DEF_W-1:0] DEFER_MAX = DEF_W'(MAX_DEFER);
  localparam logic [DEF_W-1:0] DEFER_ONE = DEF_W'(1);
  localparam logic [WIDTH-1:0] MS_ONE    = WIDTH'(1);
  localparam logic [4:0]       KEY_ADDR  = 5'(KEY_REG);
  localparam logic [4:0]       TMR_ADDR  = 5'(TIMER_REG);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_CPU,
    GRANT_KEY,
    GRANT_TMR
  } grantE;

  // State
  logic [PRE_W-1:0]    prescaler;
  logic [KEY_BITS-1:0] keyQ;
  logic [KEY_BITS-1:0] keyPend;
  logic                keyDirty;
  logic                tmrDirty;
  logic [DEF_W-1:0]    keyDefer;
  logic [DEF_W-1:0]    tmrDefer;

  // Combinational helpers
  grantE               grant;
  logic                slotEdge;
  logic                keyStarved;
  logic                tmrStarved;
  logic                tick;
  logic                keyGrant;
  logic                tmrGrant;
  logic                cpuToKeyReg;
  logic                cpuWritesRf;
  logic                keyChange;
  logic [KEY_BITS-1:0] keyRise;
  logic [KEY_BITS-1:0] keyClr;
  logic [KEY_BITS-1:0] keyPendNext;

  // The decision is taken on the edge that leaves phase 3, so the registered
  // result is visible exactly in the first cycle of phase 4.
  assign slotEdge   = (counter == 3'd3) && !stall;
  assign keyStarved = keyDirty && (keyDefer >= DEFER_MAX);
  assign tmrStarved = tmrDirty && (tmrDefer >= DEFER_MAX);
  assign tick       = (prescaler == PRE_LAST);

  // Starved sources pre-empt the CPU; keypad wins when both are starved.
  always_comb begin
    grant = GRANT_NONE;
    if (keyStarved) begin
      grant = GRANT_KEY;
    end else if (tmrStarved) begin
      grant = GRANT_TMR;
    end else if (cpu_wr_req) begin
      grant = GRANT_CPU;
    end else if (keyDirty) begin
      grant = GRANT_KEY;
    end else if (tmrDirty) begin
      grant = GRANT_TMR;
    end
  end

  assign keyGrant    = slotEdge && (grant == GRANT_KEY);
  assign tmrGrant    = slotEdge && (grant == GRANT_TMR);
  assign cpuToKeyReg = slotEdge && (grant == GRANT_CPU) && (cpu_wr_addr == KEY_ADDR);
  // Register 0 is hardwired; keypad and timer registers are owned by this block.
  assign cpuWritesRf = (cpu_wr_addr != 5'd0) && (cpu_wr_addr != KEY_ADDR)
                       && (cpu_wr_addr != TMR_ADDR);
  assign keyClr      = cpuToKeyReg ? cpu_wr_data[KEY_BITS-1:0] : '0;

  // Per-line pending bit: a rising edge sets it and outranks a same-edge W1C.
  genvar gi;
  generate
    for (gi = 0; gi < KEY_BITS; gi++) begin : genKeyLine
      assign keyRise[gi]     = keypad[gi] & ~keyQ[gi];
      assign keyPendNext[gi] = keyRise[gi] | (keyPend[gi] & ~keyClr[gi]);
    end
  endgenerate

  // Any visible change of the mask (new set or effective clear) needs a write.
  assign keyChange = (keyPendNext != keyPend);

  always_ff @(posedge clk) begin
    if (reset) begin
      counter      <= 3'd0;
      cpu_wr_ack   <= 1'b0;
      rf_we        <= 1'b0;
      rf_addr      <= 5'd0;
      rf_wdata     <= '0;
      milliseconds <= '0;
      prescaler    <= '0;
      keyQ         <= '0;
      keyPend      <= '0;
      keyDirty     <= 1'b0;
      tmrDirty     <= 1'b0;
      keyDefer     <= '0;
      tmrDefer     <= '0;
    end else begin
      if (!stall) begin
        counter <= (counter == 3'd4) ? 3'd0 : counter + 3'd1;
      end

      // Write outputs are a single-cycle pulse; idle everywhere but the slot.
      cpu_wr_ack <= 1'b0;
      rf_we      <= 1'b0;
      rf_addr    <= 5'd0;
      rf_wdata   <= '0;

      // Millisecond timer runs regardless of stall.
      if (tick) begin
        prescaler    <= '0;
        milliseconds <= milliseconds + MS_ONE;
      end else begin
        prescaler <= prescaler + PRE_ONE;
      end

      keyQ    <= keypad;
      keyPend <= keyPendNext;

      // A grant clears the dirty flag unless fresh activity lands on that edge.
      if (keyGrant) begin
        keyDirty <= keyChange;
      end else if (keyChange) begin
        keyDirty <= 1'b1;
      end

      if (tmrGrant) begin
        tmrDirty <= tick;
      end else if (tick) begin
        tmrDirty <= 1'b1;
      end

      if (slotEdge) begin
        case (grant)
          GRANT_CPU: begin
            cpu_wr_ack <= 1'b1;
            if (cpuWritesRf) begin
              rf_we    <= 1'b1;
              rf_addr  <= cpu_wr_addr;
              rf_wdata <= cpu_wr_data;
            end
          end
          GRANT_KEY: begin
            rf_we    <= 1'b1;
            rf_addr  <= KEY_ADDR;
            rf_wdata <= WIDTH'(keyPend);
          end
          GRANT_TMR: begin
            rf_we    <= 1'b1;
            rf_addr  <= TMR_ADDR;
            rf_wdata <= milliseconds;
          end
          default: begin
          end
        endcase

        // Defer counts track lost slots while dirty; saturate at MAX_DEFER.
        if (grant == GRANT_KEY) begin
          keyDefer <= '0;
        end else if (keyDirty && (keyDefer != DEFER_MAX)) begin
          keyDefer <= keyDefer + DEFER_ONE;
        end

        if (grant == GRANT_TMR) begin
          tmrDefer <= '0;
        end else if (tmrDirty && (tmrDefer != DEFER_MAX)) begin
          tmrDefer <= tmrDefer + DEFER_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_scheduler
//
// Two scheduler instances share one stimulus: a "slow" one (1000 clocks per ms,
// so the timer stays quiet during the directed sequences) and a "fast" one
// (4 clocks per ms) for timer behaviour. Both are tracked every cycle by a
// behavioural model; directed tables and sequences cover the named scenarios.
// -----------------------------------------------------------------------------
module tb_regfile_write_scheduler;

  localparam int SLOW_MS = 1000;
  localparam int FAST_MS = 4;
  localparam int MAXD    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        cpuWrReq;
  logic [4:0]  cpuWrAddr;
  logic [31:0] cpuWrData;
  logic [19:0] keypad;

  logic [2:0]  sCounter, fCounter;
  logic        sAck, fAck, sWe, fWe;
  logic [4:0]  sAddr, fAddr;
  logic [31:0] sWdata, fWdata, sMs, fMs;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(.CLK_PER_MS(SLOW_MS), .MAX_DEFER(MAXD)) dutSlow (
    .clk(clk), .reset(reset), .stall(stall), .counter(sCounter),
    .cpu_wr_req(cpuWrReq), .cpu_wr_addr(cpuWrAddr), .cpu_wr_data(cpuWrData),
    .cpu_wr_ack(sAck), .keypad(keypad), .rf_we(sWe), .rf_addr(sAddr),
    .rf_wdata(sWdata), .milliseconds(sMs)
  );

  regfile_write_scheduler #(.CLK_PER_MS(FAST_MS), .MAX_DEFER(MAXD)) dutFast (
    .clk(clk), .reset(reset), .stall(stall), .counter(fCounter),
    .cpu_wr_req(cpuWrReq), .cpu_wr_addr(cpuWrAddr), .cpu_wr_data(cpuWrData),
    .cpu_wr_ack(fAck), .keypad(keypad), .rf_we(fWe), .rf_addr(fAddr),
    .rf_wdata(fWdata), .milliseconds(fMs)
  );

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int          phase;
    logic [31:0] ms;
    int          pre;
    logic [19:0] keyQ;
    logic [19:0] pend;
    logic        keyDirty;
    logic        tmrDirty;
    int          keyDef;
    int          tmrDef;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ack;
  } model_t;

  function automatic model_t modelReset();
    model_t m;
    m.phase = 0; m.ms = '0; m.pre = 0; m.keyQ = '0; m.pend = '0;
    m.keyDirty = 1'b0; m.tmrDirty = 1'b0; m.keyDef = 0; m.tmrDef = 0;
    m.we = 1'b0; m.addr = '0; m.wdata = '0; m.ack = 1'b0;
    return m;
  endfunction

  // who: 0 nobody, 1 cpu, 2 keypad, 3 timer
  function automatic model_t modelStep(input model_t m, input int clkPerMs,
                                       input logic rst, input logic stl,
                                       input logic req, input logic [4:0] a,
                                       input logic [31:0] d, input logic [19:0] kp);
    model_t n;
    logic tick, slot;
    logic [19:0] clr, newPend;
    int who;
    if (rst) return modelReset();
    n = m;
    n.we = 1'b0; n.addr = '0; n.wdata = '0; n.ack = 1'b0;
    tick = (m.pre == clkPerMs - 1);
    n.pre = tick ? 0 : m.pre + 1;
    if (tick) n.ms = m.ms + 32'd1;
    n.keyQ = kp;
    clr = '0;
    who = 0;
    slot = (m.phase == 3) && !stl;
    if (slot) begin
      if (m.keyDirty && m.keyDef >= MAXD)      who = 2;
      else if (m.tmrDirty && m.tmrDef >= MAXD) who = 3;
      else if (req)                            who = 1;
      else if (m.keyDirty)                     who = 2;
      else if (m.tmrDirty)                     who = 3;
      if (who == 1) begin
        n.ack = 1'b1;
        if (a == 5'd29) clr = d[19:0];
        else if (a != 5'd0 && a != 5'd31) begin
          n.we = 1'b1; n.addr = a; n.wdata = d;
        end
      end else if (who == 2) begin
        n.we = 1'b1; n.addr = 5'd29; n.wdata = {12'd0, m.pend};
      end else if (who == 3) begin
        n.we = 1'b1; n.addr = 5'd31; n.wdata = m.ms;
      end
      if (who == 2) n.keyDef = 0;
      else if (m.keyDirty) n.keyDef = (m.keyDef + 1 > MAXD) ? MAXD : m.keyDef + 1;
      if (who == 3) n.tmrDef = 0;
      else if (m.tmrDirty) n.tmrDef = (m.tmrDef + 1 > MAXD) ? MAXD : m.tmrDef + 1;
    end
    newPend = (m.pend & ~clr) | (kp & ~m.keyQ);
    n.keyDirty = (slot && who == 2) ? (newPend != m.pend)
                                    : (m.keyDirty || (newPend != m.pend));
    n.pend = newPend;
    n.tmrDirty = (slot && who == 3) ? tick : (m.tmrDirty || tick);
    if (!stl) n.phase = (m.phase + 1) % 5;
    return n;
  endfunction

  model_t mS, mF;
  bit     modelValid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic cmpDut(input string tag, input model_t m, input logic [2:0] c,
                        input logic ack, input logic we, input logic [4:0] addr,
                        input logic [31:0] wd, input logic [31:0] ms);
    chk({tag, ".ctl"}, {22'd0, c, ack, we, addr},
        {22'd0, 3'(m.phase), m.ack, m.we, m.addr});
    chk({tag, ".wdata"}, wd, m.wdata);
    chk({tag, ".ms"}, ms, m.ms);
  endtask

  // One clock: advance the models on the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (modelValid || reset) begin
      mS = modelStep(mS, SLOW_MS, reset, stall, cpuWrReq, cpuWrAddr, cpuWrData, keypad);
      mF = modelStep(mF, FAST_MS, reset, stall, cpuWrReq, cpuWrAddr, cpuWrData, keypad);
      modelValid = 1'b1;
    end
    @(negedge clk);
    if (modelValid) begin
      cmpDut("modelSlow", mS, sCounter, sAck, sWe, sAddr, sWdata, sMs);
      cmpDut("modelFast", mF, fCounter, fAck, fWe, fAddr, fWdata, fMs);
    end
  endtask

  // Advance to the first cycle of the next phase 4 (bounded).
  task automatic waitSlot();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (sCounter == 3'd4) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL slotTimeout: counter %0d, required 4", sCounter);
    end
  endtask

  typedef struct { logic stl; logic [2:0] expCounter; } phase_vec_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; logic expWe; } cpu_vec_t;

  phase_vec_t phaseVec[13];
  cpu_vec_t   cpuVec[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    phaseVec[0]  = '{1'b0, 3'd1}; phaseVec[1]  = '{1'b0, 3'd2};
    phaseVec[2]  = '{1'b0, 3'd3}; phaseVec[3]  = '{1'b0, 3'd4};
    phaseVec[4]  = '{1'b0, 3'd0}; phaseVec[5]  = '{1'b0, 3'd1};
    phaseVec[6]  = '{1'b0, 3'd2}; phaseVec[7]  = '{1'b1, 3'd2};
    phaseVec[8]  = '{1'b1, 3'd2}; phaseVec[9]  = '{1'b1, 3'd2};
    phaseVec[10] = '{1'b0, 3'd3}; phaseVec[11] = '{1'b0, 3'd4};
    phaseVec[12] = '{1'b0, 3'd0};

    cpuVec[0] = '{5'd5,  32'hDEADBEEF, 1'b1};
    cpuVec[1] = '{5'd0,  32'h12345678, 1'b0};
    cpuVec[2] = '{5'd31, 32'hA5A5A5A5, 1'b0};
    cpuVec[3] = '{5'd17, 32'h0F0F0F0F, 1'b1};
    cpuVec[4] = '{5'd29, 32'h00000000, 1'b0};

    mS = modelReset();
    mF = modelReset();
    reset = 1'b1; stall = 1'b0; cpuWrReq = 1'b0; cpuWrAddr = '0;
    cpuWrData = '0; keypad = '0;

    // Reset state
    tick();
    chk("reset.counter", 32'(sCounter), 32'd0);
    chk("reset.we", 32'(sWe), 32'd0);
    chk("reset.ms", sMs, 32'd0);
    reset = 1'b0;

    // Phase sequence with a 3-cycle stall at phase 2
    for (int i = 0; i < 13; i++) begin
      stall = phaseVec[i].stl;
      tick();
      chk($sformatf("phase[%0d].counter", i), 32'(sCounter), 32'(phaseVec[i].expCounter));
      chk($sformatf("phase[%0d].we", i), 32'(sWe), 32'd0);
    end
    stall = 1'b0;

    // CPU writes to plain, zero, timer, plain and keypad registers
    for (int i = 0; i < 5; i++) begin
      cpuWrReq = 1'b1; cpuWrAddr = cpuVec[i].addr; cpuWrData = cpuVec[i].data;
      waitSlot();
      cpuWrReq = 1'b0;
      chk($sformatf("cpu[%0d].ack", i), 32'(sAck), 32'd1);
      chk($sformatf("cpu[%0d].we", i), 32'(sWe), 32'(cpuVec[i].expWe));
      if (cpuVec[i].expWe) begin
        chk($sformatf("cpu[%0d].addr", i), 32'(sAddr), 32'(cpuVec[i].addr));
        chk($sformatf("cpu[%0d].wdata", i), sWdata, cpuVec[i].data);
      end
      if (i == 0) begin
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
          tick();
          chk($sformatf("stall4[%0d].counter", k), 32'(sCounter), 32'd4);
          chk($sformatf("stall4[%0d].we", k), 32'(sWe), 32'd0);
          chk($sformatf("stall4[%0d].ack", k), 32'(sAck), 32'd0);
        end
        stall = 1'b0;
      end
    end

    // Keypad bit 3 rises, then the CPU clears it with W1C
    keypad = 20'h00008;
    waitSlot();
    chk("key.we", 32'(sWe), 32'd1);
    chk("key.addr", 32'(sAddr), 32'd29);
    chk("key.wdata", sWdata, 32'h00000008);
    chk("key.ack", 32'(sAck), 32'd0);
    cpuWrReq = 1'b1; cpuWrAddr = 5'd29; cpuWrData = 32'h8;
    waitSlot();
    cpuWrReq = 1'b0;
    chk("w1c.ack", 32'(sAck), 32'd1);
    chk("w1c.we", 32'(sWe), 32'd0);
    waitSlot();
    chk("keyClr.we", 32'(sWe), 32'd1);
    chk("keyClr.addr", 32'(sAddr), 32'd29);
    chk("keyClr.wdata", sWdata, 32'h00000000);

    // Anti-starvation: CPU requests every slot while keypad stays dirty
    keypad = 20'h00028;
    cpuWrReq = 1'b1; cpuWrAddr = 5'd7; cpuWrData = 32'h0000CAFE;
    for (int s = 1; s <= 6; s++) begin
      waitSlot();
      if (s == 5) begin
        chk("starve5.ack", 32'(sAck), 32'd0);
        chk("starve5.addr", 32'(sAddr), 32'd29);
        chk("starve5.wdata", sWdata, 32'h00000020);
      end else begin
        chk($sformatf("starve%0d.ack", s), 32'(sAck), 32'd1);
        chk($sformatf("starve%0d.addr", s), 32'(sAddr), 32'd7);
      end
      chk($sformatf("starve%0d.we", s), 32'(sWe), 32'd1);
    end
    cpuWrReq = 1'b0;

    // Timer on the fast instance: coalesced ticks, latest value written
    keypad = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 4) begin
        chk("tmr4.counter", 32'(fCounter), 32'd4);
        chk("tmr4.we", 32'(fWe), 32'd0);
      end
      if (n == 9) begin
        chk("tmr9.we", 32'(fWe), 32'd1);
        chk("tmr9.addr", 32'(fAddr), 32'd31);
        chk("tmr9.wdata", fWdata, 32'd2);
      end
      if (n == 12) chk("tmr12.ms", fMs, 32'd3);
      if (n == 14) begin
        chk("tmr14.we", 32'(fWe), 32'd1);
        chk("tmr14.wdata", fWdata, 32'd3);
      end
    end

    // Reset at phase 3 with a CPU request and a dirty keypad
    cpuWrReq = 1'b1; cpuWrAddr = 5'd9; cpuWrData = 32'h99; keypad = 20'h00001;
    for (int i = 0; i < 10 && sCounter != 3'd3; i++) tick();
    chk("midrst.pre.counter", 32'(sCounter), 32'd3);
    reset = 1'b1;
    tick();
    chk("midrst.counter", 32'(sCounter), 32'd0);
    chk("midrst.we", 32'(sWe), 32'd0);
    chk("midrst.ack", 32'(sAck), 32'd0);
    chk("midrst.ms", fMs, 32'd0);
    reset = 1'b0; cpuWrReq = 1'b0; keypad = '0;
    waitSlot();
    chk("midrst.slowSlot.we", 32'(sWe), 32'd0);
    chk("midrst.fastSlot.we", 32'(fWe), 32'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (cpuWrReq && mS.ack) cpuWrReq = 1'b0;
      if (!cpuWrReq && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 7))
          0: cpuWrAddr = 5'd0;
          1: cpuWrAddr = 5'd29;
          2: cpuWrAddr = 5'd31;
          default: cpuWrAddr = 5'($urandom);
        endcase
        cpuWrData = $urandom;
        cpuWrReq  = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) keypad[$urandom_range(0, 19)] ^= 1'b1;
      stall = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the multi-cycle phase counter that sequences the CPU register file.
- Arbitrates the register file's single write slot, which occurs in phase 4, between three sources: CPU writeback, the keypad capture register, and the millisecond timer register.
- Replaces direct hardwiring of the keypad and timer registers with scheduled writes, so every register-file write goes through one port at one phase.
- Sits between the control/datapath, the keypad pins and the register file.

Parameters:
- WIDTH, 32, register data width.
- KEY_BITS, 20, keypad line count (must be ≤ WIDTH).
- KEY_REG, 29, register index receiving the keypad pending mask.
- TIMER_REG, 31, register index receiving the millisecond count.
- CLK_PER_MS, 50000, clock cycles per millisecond tick (≥ 2).
- MAX_DEFER, 4, write slots a pending keypad/timer update may lose to the CPU before it pre-empts the CPU.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- stall, input, 1, holds the phase counter.
- counter, output, 3, current phase 0..4, registered.
- cpu_wr_req, input, 1, CPU writeback request; held until acked.
- cpu_wr_addr, input, 5, CPU destination register.
- cpu_wr_data, input, WIDTH, CPU write data.
- cpu_wr_ack, output, 1, one-cycle pulse when the CPU request is consumed.
- keypad, input, KEY_BITS, raw keypad levels (already synchronised).
- rf_we, output, 1, register file write enable.
- rf_addr, output, 5, register file write address.
- rf_wdata, output, WIDTH, register file write data.
- milliseconds, output, WIDTH, free-running millisecond count.

Behaviour:
- Reset: counter, rf_we, rf_addr, rf_wdata, cpu_wr_ack, milliseconds, prescaler, key_q, key_pend, dirty flags and defer counts all go to 0 on the first clock edge with reset=1. This applies mid-operation too; any in-flight grant is dropped.
- Phase counter: 0→1→2→3→4→0, one step per clock when stall=0; holds its value when stall=1.
- Slot: the arbitration decision is registered on the edge where counter==3 and stall=0. rf_we, rf_addr, rf_wdata and cpu_wr_ack are therefore valid in the first cycle of counter==4.
  - They are all 0 in every other cycle, including stalled repeats of phase 4.
  - Exactly one write, or none, per slot.
- Priority, default: CPU > keypad > timer.
- Anti-starvation: if key_defer ≥ MAX_DEFER, keypad outranks the CPU; otherwise, if tmr_defer ≥ MAX_DEFER, timer outranks the CPU. Keypad beats timer when both are starved.
  - A source's defer count increments on each slot where it was dirty but not granted, saturating at MAX_DEFER.
  - The count clears on grant.
- CPU grant: cpu_wr_ack=1.
  - Addr 0: acked, rf_we=0.
  - Addr TIMER_REG: acked, rf_we=0; write discarded.
  - Addr KEY_REG: acked, rf_we=0. cpu_wr_data[KEY_BITS-1:0] is write-1-to-clear on key_pend; if any pending bit changes, key_dirty is set.
  - Other addresses: rf_we=1, rf_addr=cpu_wr_addr, rf_wdata=cpu_wr_data.
- Keypad: key_q <= keypad every cycle. On rising edges (keypad & ~key_q), the corresponding key_pend bits are set and key_dirty=1 if any bit is newly set.
  - If a rising edge and a W1C hit the same bit on the same edge, the set wins.
  - Keypad grant: rf_addr=KEY_REG, rf_wdata = key_pend zero-extended to WIDTH, taken from the value at the decision edge. key_dirty clears unless a new change lands on that same edge.
- Timer: the prescaler counts 0..CLK_PER_MS-1 independent of stall. At terminal count, milliseconds increments (wrapping 2^WIDTH-1→0) and tmr_dirty=1.
  - Timer grant: rf_addr=TIMER_REG, rf_wdata = the current milliseconds value at the decision edge. Multiple ticks coalesce into one write of the latest value.
  - A tick on the grant edge re-sets tmr_dirty.
- No requester dirty/requesting: rf_we=0, cpu_wr_ack=0.

Test Plan:
- Reset, stall=0 → counter sequence 0,1,2,3,4,0,1 on successive cycles; all write outputs 0. Hold stall=1 at counter=2 for 3 cycles → counter stays 2, then resumes at 3.
- cpu_wr_req=1, addr=5, data=0xDEADBEEF → in the first phase-4 cycle rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF, cpu_wr_ack=1. Stall 2 extra cycles in phase 4 → rf_we=0 in those cycles. Addr 0 → ack=1, rf_we=0.
- keypad bit 3 rises while no CPU request → next slot writes addr 29, data 0x00000008. CPU then writes addr 29 with data 0x8 → ack, rf_we=0; following slot writes 29 with data 0x0.
- CLK_PER_MS=4: after 12 cycles milliseconds=3. Timer slot writes addr 31 with the current count; two ticks between slots → only one write, carrying the latest value.
- CPU requests every slot with keypad dirty, MAX_DEFER=4 → slots 1-4 grant CPU, slot 5 grants keypad (cpu_wr_ack=0, CPU holds), slot 6 grants CPU.
- Assert reset while counter=3 with CPU request and keypad dirty → next cycle counter=0, rf_we=0, key_pend=0, milliseconds=0; no write occurs.
